onehot_seg_display: RTL and testbench
=====================================

ONEHOT_SEG_DISPLAY -- requirements
Module: onehot_seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 20, meaning clock cycles each digit stays lit (range 2..2^26-1).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port step_in  input  21  one-hot rotating step pattern from the 0.2 s step generator.
REQ-005 SHALL have port an  output  4  digit enables, active-low, one digit enabled at a time.
REQ-006 SHALL have port seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-007 SHALL have port idx_out  output  5  binary index (0..20) of the last valid step_in.
REQ-008 SHALL have port err  output  1  high while the registered step_in is not exactly one-hot.

Function
REQ-009 SHALL register step_in in stage 1; SHALL encode it to an index and popcount check in stage 2; idx_out and err SHALL reflect a step_in change exactly 2 cycles later.
REQ-010 SHALL, when stage-1 popcount == 1, load idx_out with the set-bit position and drive err=0.
REQ-011 SHALL, when stage-1 popcount != 1 (zero or multiple bits), drive err=1 and hold idx_out and the wrap counter unchanged.
REQ-012 SHALL keep a 4-bit wrap counter (0..9): increment when a valid update changes idx_out from 20 to 0; 9 wraps to 0; no other transition changes it (including 20 -> invalid -> 0).
REQ-013 SHALL convert idx_out to BCD: tens = idx_out/10 (0..2), units = idx_out%10.
REQ-014 SHALL contain scan counter 0..SCAN_DIV-1; on reaching SCAN_DIV-1 it returns to 0 and the digit select advances 0->1->2->3->0.
REQ-015 SHALL map digit select to an: 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
REQ-016 SHALL show: digit0 units, digit1 tens (blank when tens==0), digit2 wrap counter, digit3 'E' when err=1 else blank.
REQ-017 SHALL use codes: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,E=86,blank=FF (hex, dp always 1).
REQ-018 SHALL register an and seg in the same cycle so they change together on the cycle the digit select advances; seg SHALL use idx_out/err/wrap values current at that edge.
REQ-019 SHALL let display content change mid-dwell: seg updates the cycle after idx_out/err/wrap change, without restarting the scan counter.

Reset
REQ-020 SHALL on rst=1 at a clock edge set: stage-1 register 0, idx_out=0, err=0, wrap counter 0, scan counter 0, digit select 0, an=4'b1110, seg=8'hC0.
REQ-021 SHALL give rst priority over every other event, including a scan terminal count or step change in the same cycle.
REQ-022 SHALL, after reset mid-operation, restart scanning from digit0 with a full SCAN_DIV dwell.

Structure
REQ-023 SHALL place segment code constants, digit-select encodings and the SCAN_DIV default in shared package seg_disp_pkg.
REQ-024 SHALL use one combinational sub-module seg7_decode (4-bit code plus blank/E selects -> 8-bit seg), instantiated once on the muxed digit.
REQ-025 SHALL be implementable in 120-400 lines of RTL with no latches and no clock gating.

Verification
REQ-026 SHALL cover: reset, SCAN_DIV=20 -> an=1110 for 20 cycles, then 1101, 1011, 0111, back to 1110 at cycle 80; seg=C0 on digit0, FF on digits 1 and 3, C0 on digit2.
REQ-027 SHALL cover: step_in=21'h000800 (bit 11) at cycle t -> idx_out=11 at t+2; digit0 seg=F9, digit1 seg=F9.
REQ-028 SHALL cover: drive bit20 then bit0 -> wrap counter 1, digit2 seg=F9; repeat 10 wraps -> digit2 returns to C0.
REQ-029 SHALL cover: step_in=21'h000003 -> err=1 at t+2, idx_out holds prior value, digit3 seg=86; then bit0 -> err=0, no wrap increment even if prior index was 20.
REQ-030 SHALL cover: step_in=0 -> err=1; rst asserted mid-dwell on digit2 -> next cycle an=1110, seg=C0, err=0, idx_out=0.
REQ-031 SHALL cover: step_in change in the same cycle as scan terminal count -> an advances on schedule; new digit value appears on seg no later than 3 cycles after the change.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants for the one-hot step display: segment codes, digit-select
// values and anode patterns, plus the default scan dwell.
package seg_disp_pkg;

    localparam int unsigned SCAN_DIV_DEFAULT = 20;
    localparam int unsigned SCAN_CNT_W       = 26;
    localparam int unsigned STEP_W           = 21;

    localparam logic [4:0] IDX_MAX = 5'd20;
    localparam logic [3:0] WRAP_MAX = 4'd9;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_WRAP  = 2'd2;
    localparam logic [1:0] DIG_ERR   = 2'd3;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [3:0] an_encode(input logic [1:0] sel);
        logic [3:0] an;
        case (sel)
            DIG_UNITS: an = AN_DIG0;
            DIG_TENS:  an = AN_DIG1;
            DIG_WRAP:  an = AN_DIG2;
            default:   an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: BCD digit, blank or 'E' to active-low segments.
module seg7_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    input  logic       show_e,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (show_e) begin
            seg = SEG_E;
        end else if (!blank) begin
            case (code)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/onehot_seg_display.sv
// Decodes a one-hot rotating step pattern to an index, counts 20->0 wraps and
// multiplexes index, wrap count and error flag onto a 4-digit LED display.
module onehot_seg_display
    import seg_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STEP_W-1:0]   step_in,
    output logic [3:0]          an,
    output logic [7:0]          seg,
    output logic [4:0]          idx_out,
    output logic                err
);

    localparam logic [SCAN_CNT_W-1:0] SCAN_TC = SCAN_CNT_W'(SCAN_DIV - 1);

    logic [STEP_W-1:0]     step_q, step_d;
    logic [4:0]            idx_q, idx_d;
    logic                  err_q, err_d;
    logic [3:0]            wrap_q, wrap_d;
    logic [SCAN_CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    logic [4:0] pop, pos;
    logic [3:0] tens, units;
    logic [3:0] dig_code;
    logic       dig_blank, dig_e;

    assign step_d = step_in;

    always_comb begin
        pop = '0;
        pos = '0;
        for (int i = 0; i < STEP_W; i++) begin
            if (step_q[i]) begin
                pop = pop + 5'd1;
                pos = 5'(i);
            end
        end
    end

    // A wrap only counts when the previous update was itself valid, so a
    // 20 -> invalid -> 0 sequence leaves the counter alone.
    always_comb begin
        idx_d  = idx_q;
        err_d  = err_q;
        wrap_d = wrap_q;
        if (pop == 5'd1) begin
            idx_d = pos;
            err_d = 1'b0;
            if (!err_q && idx_q == IDX_MAX && pos == 5'd0) begin
                wrap_d = (wrap_q == WRAP_MAX) ? 4'd0 : wrap_q + 4'd1;
            end
        end else begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        if (idx_q >= 5'd20) begin
            tens  = 4'd2;
            units = 4'(idx_q - 5'd20);
        end else if (idx_q >= 5'd10) begin
            tens  = 4'd1;
            units = 4'(idx_q - 5'd10);
        end else begin
            tens  = 4'd0;
            units = 4'(idx_q);
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        sel_d      = sel_q;
        if (scan_cnt_q == SCAN_TC) begin
            scan_cnt_d = '0;
            sel_d      = sel_q + 2'd1;
        end
    end

    // Mux on the next select so an and seg move together on the advancing edge.
    always_comb begin
        dig_code  = units;
        dig_blank = 1'b0;
        dig_e     = 1'b0;
        case (sel_d)
            DIG_UNITS: begin
                dig_code = units;
            end
            DIG_TENS: begin
                dig_code  = tens;
                dig_blank = (tens == 4'd0);
            end
            DIG_WRAP: begin
                dig_code = wrap_q;
            end
            default: begin
                dig_code  = 4'd0;
                dig_blank = !err_q;
                dig_e     = err_q;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .code   (dig_code),
        .blank  (dig_blank),
        .show_e (dig_e),
        .seg    (seg_d)
    );

    assign an_d = an_encode(sel_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            wrap_q     <= '0;
            scan_cnt_q <= '0;
            sel_q      <= DIG_UNITS;
            an_q       <= AN_DIG0;
            seg_q      <= SEG_0;
        end else begin
            step_q     <= step_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign idx_out = idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_onehot_seg_display.sv
// Scoreboard bench for onehot_seg_display: a cycle-count based reference model
// queues expected outputs at each rising edge; a monitor compares on the falling edge.
module tb_onehot_seg_display;

    localparam int SCAN = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] step_in = 21'h1;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [4:0]  idx_out;
    logic        err;

    onehot_seg_display #(.SCAN_DIV(SCAN)) dut (
        .clk     (clk),
        .rst     (rst),
        .step_in (step_in),
        .an      (an),
        .seg     (seg),
        .idx_out (idx_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] idx;
        logic       err;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_passed = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state
    logic [20:0] m_s1 = '0;
    int          m_idx = 0;
    bit          m_err = 0;
    int          m_wrap = 0;
    int          m_tick = 0;
    int          m_digit = 0;

    function automatic logic [7:0] disp(int digit, int idx, bit e, int wrap);
        case (digit)
            0:       return seg_tab[idx % 10];
            1:       return (idx / 10 == 0) ? 8'hFF : seg_tab[idx / 10];
            2:       return seg_tab[wrap];
            default: return e ? 8'h86 : 8'hFF;
        endcase
    endfunction

    function automatic int low_bit(logic [20:0] v);
        for (int i = 0; i < 21; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
        else
            n_passed++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_s1 = '0; m_idx = 0; m_err = 0; m_wrap = 0; m_tick = 0; m_digit = 0;
            e.an  = 4'b1110;
            e.seg = 8'hC0;
        end else begin
            m_tick++;
            m_digit = (m_tick / SCAN) % 4;
            e.an  = ~(4'b0001 << m_digit);
            e.seg = disp(m_digit, m_idx, m_err, m_wrap);
            if ($countones(m_s1) == 1) begin
                if (!m_err && m_idx == 20 && low_bit(m_s1) == 0)
                    m_wrap = (m_wrap + 1) % 10;
                m_idx = low_bit(m_s1);
                m_err = 0;
            end else begin
                m_err = 1;
            end
            m_s1 = step_in;
        end
        e.idx = 5'(m_idx);
        e.err = m_err;
        exp_q.push_back(e);
    end

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("idx_out", 32'(idx_out), 32'(e.idx));
                chk("err",     32'(err),     32'(e.err));
                chk("an",      32'(an),      32'(e.an));
                chk("seg",     32'(seg),     32'(e.seg));
            end
        end
    end

    task automatic drive(logic [20:0] v, int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b0;
            step_in = v;
        end
    endtask

    initial begin
        logic [20:0] v;
        int r;
        repeat (2) @(negedge clk);
        // Full scan rotation on idx 0
        drive(21'h000001, 90);
        // Index 11
        drive(21'h000800, 30);
        // Eleven 20 -> 0 wraps, ending at wrap count 1
        for (int w = 0; w < 11; w++) begin
            drive(21'h100000, 4);
            drive(21'h000001, 4);
        end
        drive(21'h000001, 60);
        // 20 -> invalid -> 0 must not wrap
        drive(21'h100000, 4);
        drive(21'h000003, 4);
        drive(21'h000001, 85);
        // Zero pattern, then reset mid-dwell on digit 2
        drive(21'h000000, 3);
        for (int k = 0; k < 100 && m_digit != 2; k++) drive(21'h000000, 1);
        drive(21'h000000, 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(21'h000004, 50);
        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            rst = (r == 0);
            if (r < 20) begin
                v = 21'h1;
                step_in = v << $urandom_range(0, 20);
            end else if (r < 24) begin
                step_in = 21'($urandom);
            end else if (r < 27) begin
                step_in = '0;
            end else if (r < 35) begin
                step_in = (step_in == 21'h100000) ? 21'h1 : 21'h100000;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
